uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//  Memory-mapped UART receiver: the input-direction peripheral on the CPU data-memory bus, complementing
//  the LED/7-seg output devices. Deserialises 8N1 frames from the board RX pin into a byte FIFO; the CPU
//  reads data and status with lw and clears error flags with sw. It decodes the same MemRead/MemWrite/
//  address bus that the data memory receives, and its rdata is muxed into the load path beside it.
// PARAMETERS
//  CLK_HZ      100_000_000   clk frequency in Hz
//  BAUD        115200        line rate; OVS = 16 samples per bit, DIV = CLK_HZ/(BAUD*16), rounded down
//  FIFO_DEPTH  8             RX FIFO entries, power of two, 2..16
//  BASE_ADDR   32'h4000_0020 byte address of RXDATA; RXSTAT = BASE+4, RXCTRL = BASE+8
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous, active-high reset
//  rx        in   1   asynchronous serial input, idle high
//  addr      in   32  data-bus byte address (EX/MEM ALU result)
//  MemRead   in   1   bus read strobe
//  MemWrite  in   1   bus write strobe
//  wdata     in   32  bus write data
//  rdata     out  32  combinational read data; 0 when the address does not hit this block
//  irq       out  1   registered: RXCTRL.irq_en & fifo_not_empty
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, overrun=0, frame_err=0, RXCTRL=2'b01 (enable=1, irq_en=0), irq=0,
//   synchroniser stages=1, tick divider=0. rdata needs no reset because it is combinational.
//  Registers:
//   RXDATA (read): {24'b0, FIFO head}. The head is popped at the clk edge that samples MemRead with
//    addr==BASE. A read while empty returns 0 and pops nothing. Writes are ignored.
//   RXSTAT (read): bit0 not_empty, bit1 overrun, bit2 frame_err, bits[8:4] count, other bits 0.
//    A write with wdata bit1/bit2 = 1 clears the corresponding sticky flag (write-1-to-clear).
//   RXCTRL (read/write): bit0 enable, bit1 irq_en.
//  Input: rx passes through a 2-FF synchroniser before use. The tick strobe pulses once every DIV clks
//   and its counter runs only while the FSM is not IDLE. It is restarted on the IDLE->START transition.
//  FSM (4 states):
//   IDLE : enable & rx_s==0 -> START
//   START: after 8 ticks (mid start bit), rx_s==0 -> DATA, else -> IDLE (glitch rejected, no flag)
//   DATA : sample rx_s every 16 ticks, LSB first, into a shift register. After bit 7 -> STOP
//   STOP : after 16 ticks, sample rx_s
//          - rx_s==1: push the byte (if full: drop it, set overrun), then -> IDLE
//          - rx_s==0: set frame_err, drop the byte, then -> IDLE
//   enable=0 in any state forces IDLE at the next edge and aborts the frame silently.
//  Latency: a byte becomes visible in RXSTAT one clk after the mid-stop-bit sample.
//  Push and pop in the same cycle when full: the pop happens first, the push succeeds, count is
//   unchanged, no overrun. Push and pop when empty: the read returns 0 and the byte is stored.
//  FIFO order is strictly first-in first-out. Pointers are log2(DEPTH) bits and wrap. count is
//   log2(DEPTH)+1 bits wide.
//  Reset mid-frame discards the partial byte and clears all FIFO contents and flags.
// STRUCTURE
//  Shared package: register offsets (RXDATA_OFS=0, RXSTAT_OFS=4, RXCTRL_OFS=8), RXSTAT bit indices,
//   OVS=16, and the FSM state encoding.
//  One sub-module, rx_fifo: synchronous FIFO (push, pop, din, dout, full, empty, count).
//  The deserialiser FSM, bus decode and registers stay in this module.
// TESTING (DIV reduced to 4 via CLK_HZ/BAUD for the bench)
//  1. Send 0xA5 as 8N1 -> RXSTAT reads 0x11, irq stays 0 (irq_en=0). Read RXDATA=0x0000_00A5.
//     RXSTAT then reads 0x0.
//  2. Drive an rx low pulse of 3 ticks, then return high -> no push, RXSTAT=0, FSM back in IDLE.
//  3. Send 0x3C with the stop bit low -> RXSTAT=0x4, FIFO empty. Write RXSTAT=0x4 -> RXSTAT=0x0.
//  4. Send 9 bytes 0x01..0x09 without reading -> RXSTAT=0x83 (count 8, overrun, not_empty).
//     Reads return 0x01..0x08 in order.
//  5. With the FIFO full, issue the RXDATA read in the same clk as the stop-bit push -> count stays 8,
//     overrun stays 0, the new byte is last out.
//  6. Set RXCTRL=0x3 and send 0x55 -> irq rises one clk after the push. Assert reset mid-data-bit of
//     the next frame -> FIFO empty, irq=0, the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Contents:
//   - register byte offsets relative to BASE_ADDR
//   - RXSTAT bit positions
//   - oversampling factor (samples per bit)
//   - deserialiser FSM state encoding
//   - calc_div(): baud-tick divider derived from clock and line rate
package uart_rx_mmio_pkg;

  localparam logic [31:0] RXDATA_OFS = 32'd0;
  localparam logic [31:0] RXSTAT_OFS = 32'd4;
  localparam logic [31:0] RXCTRL_OFS = 32'd8;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_OVERRUN   = 1;
  localparam int STAT_FRAME_ERR = 2;
  localparam int STAT_COUNT_LSB = 4;

  localparam int OVS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  // Clocks per oversample tick, rounded down, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVS);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_mmio_rx_fifo.sv
// Synchronous byte FIFO holding received characters until the CPU reads them.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write request and byte; accepted when not full, or when full
//                 together with an effective pop in the same cycle
//   pop         : read request; ignored when empty
//   dout        : head entry (valid only when not empty)
//   full, empty : occupancy flags
//   count       : number of stored entries, log2(DEPTH)+1 bits
module rx_fifo
  import uart_rx_mmio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty = (r_count == (AW + 1)'(0));
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rptr];

  // The pop is resolved first, so a full FIFO can still accept a same-cycle push.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers (power-of-two depth, so they wrap naturally) and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= (AW + 1)'(0);
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver on the CPU data bus.
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   rx               : asynchronous serial input, idle high
//   addr             : data-bus byte address
//   MemRead/MemWrite : bus strobes
//   wdata            : bus write data
//   rdata            : combinational read data, 0 when the address misses
//   irq              : registered, RXCTRL.irq_en & FIFO not empty
// Map: BASE+0 RXDATA (read pops), BASE+4 RXSTAT (W1C flags), BASE+8 RXCTRL.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [31:0] addr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int DIV    = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W = $clog2(OVS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rx_s;
  rx_state_t         r_state;
  rx_state_t         w_next_state;
  logic [DIV_W-1:0]  r_div;
  logic [TCNT_W-1:0] r_tcnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [1:0]        r_ctrl;
  logic              r_overrun;
  logic              r_frame_err;
  logic              r_irq;
  logic              w_tick;
  logic              w_mid_start;
  logic              w_sample;
  logic              w_push;
  logic              w_frame_set;
  logic              w_shift_en;
  logic              w_hit_data;
  logic              w_hit_stat;
  logic              w_hit_ctrl;
  logic              w_pop_req;
  logic              w_pop_eff;
  logic              w_overrun_set;
  logic [7:0]        w_dout;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [31:0]       w_stat;
  logic              w_unused_wdata;

  assign w_rx_s      = r_sync2;
  assign w_tick      = (r_state != ST_IDLE) && (r_div == DIV_W'(DIV - 1));
  assign w_mid_start = w_tick && (r_tcnt == TCNT_W'(OVS / 2 - 1));
  assign w_sample    = w_tick && (r_tcnt == TCNT_W'(OVS - 1));

  assign w_hit_data = (addr == (BASE_ADDR + RXDATA_OFS));
  assign w_hit_stat = (addr == (BASE_ADDR + RXSTAT_OFS));
  assign w_hit_ctrl = (addr == (BASE_ADDR + RXCTRL_OFS));

  assign w_pop_req     = MemRead & w_hit_data;
  assign w_pop_eff     = w_pop_req & ~w_empty;
  // A push into a full FIFO only overflows if no pop frees a slot in the same cycle.
  assign w_overrun_set = w_push & w_full & ~w_pop_eff;

  assign w_unused_wdata = ^{wdata[31:3], wdata[0]};
  assign irq = r_irq;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; dropping enable aborts any frame in progress.
  always_comb begin
    w_next_state = r_state;
    if (!r_ctrl[0]) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) w_next_state = ST_START;
          else         w_next_state = ST_IDLE;
        end
        ST_START: begin
          // Line back high at mid start bit means a glitch, not a frame.
          if (w_mid_start) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
          else             w_next_state = ST_START;
        end
        ST_DATA: begin
          if (w_sample && (r_bit == 3'd7)) w_next_state = ST_STOP;
          else                             w_next_state = ST_DATA;
        end
        ST_STOP: begin
          if (w_sample) w_next_state = ST_IDLE;
          else          w_next_state = ST_STOP;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: data-bit shift, stop-bit push or framing error.
  always_comb begin
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      ST_DATA: begin
        w_shift_en = r_ctrl[0] & w_sample;
      end
      ST_STOP: begin
        w_push      = r_ctrl[0] & w_sample & w_rx_s;
        w_frame_set = r_ctrl[0] & w_sample & ~w_rx_s;
      end
      default: begin
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
      end
    endcase
  end

  // Bit timing: divider, ticks within a bit, data bit index. Held at zero in IDLE,
  // so every frame starts counting from the IDLE->START transition.
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_IDLE)) begin
      r_div  <= DIV_W'(0);
      r_tcnt <= TCNT_W'(0);
      r_bit  <= 3'd0;
    end else if (w_tick) begin
      r_div <= DIV_W'(0);
      // Realign the tick counter at mid start bit so later samples land mid-bit.
      if (w_mid_start && (r_state == ST_START)) r_tcnt <= TCNT_W'(0);
      else                                      r_tcnt <= r_tcnt + TCNT_W'(1);
      if (w_shift_en) r_bit <= r_bit + 3'd1;
      else            r_bit <= r_bit;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Receive shift register, LSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= 8'd0;
    end else if (w_shift_en) begin
      r_shift <= {w_rx_s, r_shift[7:1]};
    end else begin
      r_shift <= r_shift;
    end
  end

  // Control register, sticky error flags (set wins over W1C) and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= 2'b01;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (MemWrite && w_hit_ctrl) r_ctrl <= wdata[1:0];
      if (w_overrun_set)                                      r_overrun <= 1'b1;
      else if (MemWrite && w_hit_stat && wdata[STAT_OVERRUN]) r_overrun <= 1'b0;
      if (w_frame_set)                                          r_frame_err <= 1'b1;
      else if (MemWrite && w_hit_stat && wdata[STAT_FRAME_ERR]) r_frame_err <= 1'b0;
      r_irq <= r_ctrl[1] & ~w_empty;
    end
  end

  rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop_req),
    .din   (r_shift),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_stat = (32'(w_count) << STAT_COUNT_LSB)
                | {29'd0, r_frame_err, r_overrun, ~w_empty};

  // Read mux; an empty RXDATA read returns zero.
  always_comb begin
    rdata = 32'd0;
    if (w_hit_data) begin
      rdata = w_empty ? 32'd0 : {24'd0, w_dout};
    end else if (w_hit_stat) begin
      rdata = w_stat;
    end else if (w_hit_ctrl) begin
      rdata = {30'd0, r_ctrl};
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio with a 4-clock oversample tick (64 clocks per bit).
module tb_uart_rx_mmio;

  localparam logic [31:0] BASE    = 32'h4000_0020;
  localparam logic [31:0] A_DATA  = BASE;
  localparam logic [31:0] A_STAT  = BASE + 32'd4;
  localparam logic [31:0] A_CTRL  = BASE + 32'd8;
  localparam int          BIT_CYC = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] addr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] g_rd;
  logic        g_irq_push;
  logic        g_irq_after;

  typedef struct packed {
    logic [7:0]  data;
    logic        stop;
    logic [31:0] stat;
    logic [31:0] rdv;
    logic [31:0] stat_after;
  } vec_t;

  vec_t vecs [6];

  uart_rx_mmio #(
    .CLK_HZ     (64),
    .BAUD       (1),
    .FIFO_DEPTH (8),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .addr     (addr),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; MemRead = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 MemRead = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; MemWrite = 1'b1;
    @(posedge clk);
    #1 MemWrite = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  // One 8N1 frame, one negedge per clock. The stop-bit push lands on the edge
  // that ends cycle 610 (2 sync + 1 FSM + 152 ticks * 4), so a read placed in
  // cycle 610 is sampled by the same edge. irq is captured right after that
  // edge and one edge later.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_cyc);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      @(negedge clk);
      rx = fr[c / BIT_CYC];
      if (c == rd_cyc) begin addr = A_DATA; MemRead = 1'b1; end
      else begin MemRead = 1'b0; end
      #1;
      if (c == rd_cyc) g_rd = rdata;
      if (c == 611) g_irq_push = irq;
      if (c == 612) g_irq_after = irq;
    end
    @(negedge clk);
    rx = 1'b1; MemRead = 1'b0; addr = 32'd0;
    repeat (100) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    vecs[0] = '{8'hA5, 1'b1, 32'h11, 32'hA5, 32'h00};
    vecs[1] = '{8'h3C, 1'b0, 32'h04, 32'h00, 32'h04};
    vecs[2] = '{8'h00, 1'b1, 32'h11, 32'h00, 32'h00};
    vecs[3] = '{8'hFF, 1'b1, 32'h11, 32'hFF, 32'h00};
    vecs[4] = '{8'h81, 1'b1, 32'h11, 32'h81, 32'h00};
    vecs[5] = '{8'h7E, 1'b0, 32'h04, 32'h00, 32'h04};

    reset = 1'b1; rx = 1'b1; addr = 32'd0; MemRead = 1'b0; MemWrite = 1'b0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reset state and decode
    check("reset irq", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, d); check("reset RXSTAT", d, 32'h0);
    bus_read(A_CTRL, d); check("reset RXCTRL", d, 32'h1);
    bus_read(A_DATA, d); check("empty RXDATA", d, 32'h0);
    bus_read(BASE + 32'd12, d); check("unmapped rdata", d, 32'h0);
    bus_write(A_DATA, 32'hFF); bus_read(A_STAT, d); check("RXDATA write ignored", d, 32'h0);

    // Receiver disabled: frame ignored
    bus_write(A_CTRL, 32'h0);
    send_frame(8'h5A, 1'b1, -1);
    bus_read(A_STAT, d); check("disabled no rx", d, 32'h0);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d); check("RXCTRL readback", d, 32'h1);

    // Table-driven single frames (includes 0xA5 and framing-error 0x3C)
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, -1);
      check($sformatf("vec%0d irq", i), {31'd0, g_irq_after}, 32'd0);
      bus_read(A_STAT, d); check($sformatf("vec%0d stat", i), d, vecs[i].stat);
      bus_read(A_DATA, d); check($sformatf("vec%0d data", i), d, vecs[i].rdv);
      bus_read(A_STAT, d); check($sformatf("vec%0d stat after read", i), d, vecs[i].stat_after);
      bus_write(A_STAT, 32'h4);
      bus_read(A_STAT, d); check($sformatf("vec%0d stat cleared", i), d, 32'h0);
    end

    // Start-bit glitch of 3 ticks: rejected, then a clean frame still works
    @(negedge clk) rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(A_STAT, d); check("glitch stat", d, 32'h0);
    send_frame(8'h96, 1'b1, -1);
    bus_read(A_STAT, d); check("post-glitch stat", d, 32'h11);
    bus_read(A_DATA, d); check("post-glitch data", d, 32'h96);

    // Overrun: 9 bytes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1);
    bus_read(A_STAT, d); check("overrun stat", d, 32'h83);
    for (int i = 1; i <= 8; i++) begin
      bus_read(A_DATA, d); check($sformatf("overrun data%0d", i), d, 32'(i));
    end
    bus_read(A_STAT, d); check("overrun drained", d, 32'h02);
    bus_write(A_STAT, 32'h2);
    bus_read(A_STAT, d); check("overrun cleared", d, 32'h0);

    // Full FIFO with pop in the same cycle as the push
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, -1);
    bus_read(A_STAT, d); check("full stat", d, 32'h81);
    send_frame(8'h19, 1'b1, 610);
    check("same-cycle pop data", g_rd, 32'h11);
    bus_read(A_STAT, d); check("same-cycle stat", d, 32'h81);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_DATA, d); check($sformatf("fifo order %0d", i), d, 32'h12 + 32'(i));
    end
    bus_read(A_STAT, d); check("fifo drained", d, 32'h0);

    // irq enabled, then reset mid-data of the following frame
    bus_write(A_CTRL, 32'h3);
    send_frame(8'h55, 1'b1, -1);
    check("irq at push edge", {31'd0, g_irq_push}, 32'd0);
    check("irq one clk later", {31'd0, g_irq_after}, 32'd1);
    check("irq held", {31'd0, irq}, 32'd1);
    begin
      logic [9:0] fr;
      fr = {1'b1, 8'hAA, 1'b0};
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        rx = fr[c / BIT_CYC];
      end
    end
    @(negedge clk); reset = 1'b1; rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("irq after reset", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, d); check("stat after reset", d, 32'h0);
    bus_read(A_CTRL, d); check("ctrl after reset", d, 32'h1);
    send_frame(8'hC3, 1'b1, -1);
    bus_read(A_STAT, d); check("post-reset stat", d, 32'h11);
    bus_read(A_DATA, d); check("post-reset data", d, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
